pe_mat_tile: RTL

PE_MAT_TILE -- requirements
Module: pe_mat_tile

---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_mac.sv | 70 +++++++
 rtl/pe_mat_tile.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the output-stationary MAC tile.
//   pe_state_e : tile sequencing states
//   acc_width  : default accumulator width for a given operand width
package pe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } pe_state_e;

  // Full-width product plus four guard bits of accumulation headroom.
  function automatic int acc_width(input int width);
    return 2 * width + 4;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Single output-stationary MAC cell.
// Ports:
//   clk, rst            : clock, async active-high reset
//   adv                 : array advance strobe (shift operands, allow MAC)
//   clr                 : first beat of a fresh tile, restart the accumulator
//   a_in/a_vld_in       : operand from the left neighbour (or row skew line)
//   b_in/b_vld_in       : operand from the upper neighbour (or column skew line)
//   a_out/a_vld_out     : registered pass-through to the right neighbour
//   b_out/b_vld_out     : registered pass-through to the lower neighbour
//   acc                 : accumulated result C[i][j]
module pe_mac
  import pe_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ACC_W  = acc_width(4),
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             clr,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_vld_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_vld_in,
  output logic [WIDTH-1:0] a_out,
  output logic             a_vld_out,
  output logic [WIDTH-1:0] b_out,
  output logic             b_vld_out,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] prod_ext;
  logic             mac_en;

  if (SIGNED != 0) begin : g_signed
    logic signed [2*WIDTH-1:0] prod_s;
    assign prod_s   = $signed({{WIDTH{a_in[WIDTH-1]}}, a_in}) *
                      $signed({{WIDTH{b_in[WIDTH-1]}}, b_in});
    assign prod_ext = ACC_W'(prod_s);
  end else begin : g_unsigned
    logic [2*WIDTH-1:0] prod_u;
    assign prod_u   = {{WIDTH{1'b0}}, a_in} * {{WIDTH{1'b0}}, b_in};
    assign prod_ext = ACC_W'(prod_u);
  end

  assign mac_en = adv && a_vld_in && b_vld_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
      acc       <= '0;
    end else begin
      if (adv) begin
        a_out     <= a_in;
        a_vld_out <= a_vld_in;
        b_out     <= b_in;
        b_vld_out <= b_vld_in;
      end
      // Clearing and the first product land on the same edge, so cell (0,0)
      // does not lose beat 0 of a fresh tile.
      if (clr)         acc <= mac_en ? prod_ext : '0;
      else if (mac_en) acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/pe_mat_tile.sv
// N x N output-stationary matrix-multiply tile: C = sum_k A[:,k] x B[k,:].
// Ports:
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready             : operand beat handshake
//   in_a, in_b                    : column k of A, row k of B
//   in_last, in_acc               : final beat marker, keep-accumulators on first beat
//   out_valid/out_ready           : result row handshake
//   out_row, out_idx, out_last    : row C[r][*], r, r == N-1
//   busy                          : not idle
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | waiting for the first beat of a tile
// ST_LOAD  | accepting beats, array advancing every cycle
// ST_FLUSH | no more beats, pushing bubbles until all cells done
// ST_DRAIN | presenting result rows 0..N-1
module pe_mat_tile
  import pe_pkg::*;
#(
  parameter int N      = 2,
  parameter int WIDTH  = 4,
  parameter int ACC_W  = acc_width(WIDTH),
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     in_a,
  input  logic [N*WIDTH-1:0]     in_b,
  input  logic                   in_last,
  input  logic                   in_acc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACC_W-1:0]     out_row,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   out_last,
  output logic                   busy
);

  localparam int              RW        = $clog2(N);
  localparam int              FW        = $clog2(2 * N);
  localparam logic [FW-1:0]   FLUSH_END = FW'(2 * N - 1);
  localparam logic [RW-1:0]   ROW_END   = RW'(N - 1);

  pe_state_e       state, state_nxt;
  logic            accept, adv, clr, row_hs;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row_cnt;

  logic [WIDTH-1:0] a_row [N];
  logic             av_row [N];
  logic [WIDTH-1:0] b_col [N];
  logic             bv_col [N];

  logic [WIDTH-1:0] a_lnk  [N][N];
  logic             av_lnk [N][N];
  logic [WIDTH-1:0] b_lnk  [N][N];
  logic             bv_lnk [N][N];
  logic [ACC_W-1:0] acc_arr [N][N];

  assign in_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign accept    = in_valid && in_ready;
  assign adv       = accept || (state == ST_LOAD) || (state == ST_FLUSH);
  assign clr       = accept && (state == ST_IDLE) && !in_acc;
  assign out_valid = (state == ST_DRAIN);
  assign row_hs    = out_valid && out_ready;
  assign out_idx   = row_cnt;
  assign out_last  = out_valid && (row_cnt == ROW_END);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = in_last ? ST_FLUSH : ST_LOAD;
      ST_LOAD:  if (accept && in_last) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == FLUSH_END) state_nxt = ST_DRAIN;
      ST_DRAIN: if (row_hs && out_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FLUSH) flush_cnt <= (flush_cnt == FLUSH_END) ? '0 : flush_cnt + FW'(1);
      else                   flush_cnt <= '0;
      if (row_hs)            row_cnt   <= out_last ? '0 : row_cnt + RW'(1);
    end
  end

  // Row i of A and column i of B are delayed by i stages so that beat k
  // reaches cell (i,j) on cycle k+i+j from both directions.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [WIDTH-1:0] a_inj, b_inj;
    assign a_inj = in_a[gi*WIDTH +: WIDTH];
    assign b_inj = in_b[gi*WIDTH +: WIDTH];
    if (gi == 0) begin : g_direct
      assign a_row[0]  = a_inj;
      assign av_row[0] = accept;
      assign b_col[0]  = b_inj;
      assign bv_col[0] = accept;
    end else begin : g_delay
      logic [WIDTH-1:0] a_sk  [gi];
      logic             av_sk [gi];
      logic [WIDTH-1:0] b_sk  [gi];
      logic             bv_sk [gi];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < gi; s++) begin
            a_sk[s]  <= '0;
            av_sk[s] <= 1'b0;
            b_sk[s]  <= '0;
            bv_sk[s] <= 1'b0;
          end
        end else if (adv) begin
          a_sk[0]  <= a_inj;
          av_sk[0] <= accept;
          b_sk[0]  <= b_inj;
          bv_sk[0] <= accept;
          for (int s = 1; s < gi; s++) begin
            a_sk[s]  <= a_sk[s-1];
            av_sk[s] <= av_sk[s-1];
            b_sk[s]  <= b_sk[s-1];
            bv_sk[s] <= bv_sk[s-1];
          end
        end
      end
      assign a_row[gi]  = a_sk[gi-1];
      assign av_row[gi] = av_sk[gi-1];
      assign b_col[gi]  = b_sk[gi-1];
      assign bv_col[gi] = bv_sk[gi-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [WIDTH-1:0] a_i, b_i;
      logic             av_i, bv_i;
      if (gj == 0) begin : g_a_edge
        assign a_i  = a_row[gi];
        assign av_i = av_row[gi];
      end else begin : g_a_chain
        assign a_i  = a_lnk[gi][gj-1];
        assign av_i = av_lnk[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_i  = b_col[gj];
        assign bv_i = bv_col[gj];
      end else begin : g_b_chain
        assign b_i  = b_lnk[gi-1][gj];
        assign bv_i = bv_lnk[gi-1][gj];
      end
      pe_mac #(
        .WIDTH  (WIDTH),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .clr       (clr),
        .a_in      (a_i),
        .a_vld_in  (av_i),
        .b_in      (b_i),
        .b_vld_in  (bv_i),
        .a_out     (a_lnk[gi][gj]),
        .a_vld_out (av_lnk[gi][gj]),
        .b_out     (b_lnk[gi][gj]),
        .b_vld_out (bv_lnk[gi][gj]),
        .acc       (acc_arr[gi][gj])
      );
    end
  end

  // Pass-through outputs of the last column and last row feed nothing.
  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < N; i++) begin
      unused_edge = unused_edge ^ (^a_lnk[i][N-1]) ^ av_lnk[i][N-1] ^
                    (^b_lnk[N-1][i]) ^ bv_lnk[N-1][i];
    end
  end

  // Accumulators are frozen in DRAIN, so the selected row is stable while stalled.
  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) out_row[j*ACC_W +: ACC_W] = acc_arr[row_cnt][j];
    end
  end

endmodule
